// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding, port ids
// and default bus widths.
package ram_port_arbiter_pkg;

   localparam int DEF_ADDR_W = 15;
   localparam int DEF_DATA_W = 16;

   // Wide enough to hold the largest legal read latency (3).
   localparam int CNT_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between a CPU
// data port and an auxiliary port, with req/ack handshakes and registered read data.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RD_LATENCY = 1
) (
   input  logic              i_CLK,
   input  logic              i_RESET,
   input  logic              i_REQ0,
   input  logic              i_REQ1,
   input  logic              i_WE0,
   input  logic              i_WE1,
   input  logic [ADDR_W-1:0] i_ADDR0,
   input  logic [ADDR_W-1:0] i_ADDR1,
   input  logic [DATA_W-1:0] i_WDATA0,
   input  logic [DATA_W-1:0] i_WDATA1,
   output logic              o_ACK0,
   output logic              o_ACK1,
   output logic [DATA_W-1:0] o_RDATA0,
   output logic [DATA_W-1:0] o_RDATA1,
   output logic              o_RAM_EN,
   output logic              o_RAM_WE,
   output logic [ADDR_W-1:0] o_RAM_ADDR,
   output logic [DATA_W-1:0] o_RAM_WDATA,
   input  logic [DATA_W-1:0] i_RAM_RDATA,
   output logic              o_BUSY
);

   if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_rd_latency
      $error("ram_port_arbiter: RD_LATENCY=%0d is outside 1..3", RD_LATENCY);
   end

   state_t            state;
   state_t            state_next;
   logic              req_any;
   logic              pick;
   logic              last_grant;
   logic              grant_id;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [CNT_W-1:0]  wait_cnt;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;

   // A lone request wins outright; on a tie the port not granted last time wins.
   assign req_any = i_REQ0 | i_REQ1;
   assign pick    = (i_REQ0 & i_REQ1) ? ~last_grant : i_REQ1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_next  = state;
      o_RAM_EN    = 1'b0;
      o_RAM_WE    = 1'b0;
      o_RAM_ADDR  = '0;
      o_RAM_WDATA = '0;
      o_ACK0      = 1'b0;
      o_ACK1      = 1'b0;
      o_BUSY      = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (req_any) state_next = ISSUE;
         end
         ISSUE: begin
            o_RAM_EN    = 1'b1;
            o_RAM_WE    = lat_we;
            o_RAM_ADDR  = lat_addr;
            o_RAM_WDATA = lat_wdata;
            state_next  = lat_we ? ACK : WAIT;
         end
         WAIT: begin
            if (wait_cnt == CNT_W'(1)) state_next = ACK;
         end
         ACK: begin
            o_ACK0     = (grant_id == PORT_CPU);
            o_ACK1     = (grant_id == PORT_AUX);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latch, grant bookkeeping and read-latency countdown.
   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         last_grant <= PORT_AUX;
         grant_id   <= PORT_CPU;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         wait_cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_any) begin
                  grant_id   <= pick;
                  last_grant <= pick;
                  lat_we     <= pick ? i_WE1    : i_WE0;
                  lat_addr   <= pick ? i_ADDR1  : i_ADDR0;
                  lat_wdata  <= pick ? i_WDATA1 : i_WDATA0;
               end
            end
            ISSUE: begin
               if (!lat_we) wait_cnt <= CNT_W'(RD_LATENCY);
            end
            WAIT: begin
               wait_cnt <= wait_cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Read data is captured once, on the last wait cycle, and held until the
   // next read on the same port.
   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (state == WAIT && wait_cnt == CNT_W'(1)) begin
         if (grant_id == PORT_AUX) rdata1_q <= i_RAM_RDATA;
         else                      rdata0_q <= i_RAM_RDATA;
      end
   end

   assign o_RDATA0 = rdata0_q;
   assign o_RDATA1 = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: one instance with RD_LATENCY=1 and one
// with RD_LATENCY=3, each attached to a behavioural RAM with matching latency.
module tb_ram_port_arbiter;

   typedef struct {
      logic        port;
      logic        rd;
      logic [15:0] rdata;
      int          cyc;
   } ack_exp_t;

   typedef struct {
      logic        we;
      logic [14:0] addr;
      logic [15:0] wdata;
      int          cyc;
   } ram_exp_t;

   typedef struct {
      logic        we;
      logic [14:0] addr;
      logic [15:0] wdata;
   } txn_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A: RD_LATENCY = 1
   logic        rst, req0, req1, we0, we1;
   logic [14:0] addr0, addr1, ram_addr;
   logic [15:0] wdata0, wdata1, rdata0, rdata1, ram_wdata, ram_rdata;
   logic        ack0, ack1, ram_en, ram_we, busy;

   // Instance B: RD_LATENCY = 3
   logic        rst_b, req0_b, req1_b, we0_b, we1_b;
   logic [14:0] addr0_b, addr1_b, ram_addr_b;
   logic [15:0] wdata0_b, wdata1_b, rdata0_b, rdata1_b, ram_wdata_b, ram_rdata_b;
   logic        ack0_b, ack1_b, ram_en_b, ram_we_b, busy_b;

   ram_port_arbiter #(.ADDR_W(15), .DATA_W(16), .RD_LATENCY(1)) dut (
      .i_CLK(clk), .i_RESET(rst),
      .i_REQ0(req0), .i_REQ1(req1), .i_WE0(we0), .i_WE1(we1),
      .i_ADDR0(addr0), .i_ADDR1(addr1), .i_WDATA0(wdata0), .i_WDATA1(wdata1),
      .o_ACK0(ack0), .o_ACK1(ack1), .o_RDATA0(rdata0), .o_RDATA1(rdata1),
      .o_RAM_EN(ram_en), .o_RAM_WE(ram_we), .o_RAM_ADDR(ram_addr),
      .o_RAM_WDATA(ram_wdata), .i_RAM_RDATA(ram_rdata), .o_BUSY(busy)
   );

   ram_port_arbiter #(.ADDR_W(15), .DATA_W(16), .RD_LATENCY(3)) dut_b (
      .i_CLK(clk), .i_RESET(rst_b),
      .i_REQ0(req0_b), .i_REQ1(req1_b), .i_WE0(we0_b), .i_WE1(we1_b),
      .i_ADDR0(addr0_b), .i_ADDR1(addr1_b), .i_WDATA0(wdata0_b), .i_WDATA1(wdata1_b),
      .o_ACK0(ack0_b), .o_ACK1(ack1_b), .o_RDATA0(rdata0_b), .o_RDATA1(rdata1_b),
      .o_RAM_EN(ram_en_b), .o_RAM_WE(ram_we_b), .o_RAM_ADDR(ram_addr_b),
      .o_RAM_WDATA(ram_wdata_b), .i_RAM_RDATA(ram_rdata_b), .o_BUSY(busy_b)
   );

   // Behavioural RAMs; 16'hDEAD marks data that should never be captured.
   logic [15:0] mem_a [0:32767];
   logic [15:0] mem_b [0:32767];
   logic [15:0] pipe_a;
   logic [15:0] pipe_b [0:2];

   always @(posedge clk) begin
      if (ram_en && ram_we) mem_a[ram_addr] <= ram_wdata;
      pipe_a <= (ram_en && !ram_we) ? mem_a[ram_addr] : 16'hDEAD;
   end
   assign ram_rdata = pipe_a;

   always @(posedge clk) begin
      if (ram_en_b && ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
      pipe_b[0] <= (ram_en_b && !ram_we_b) ? mem_b[ram_addr_b] : 16'hDEAD;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign ram_rdata_b = pipe_b[2];

   ack_exp_t sb_a[$];
   ack_exp_t sb_b[$];
   ram_exp_t sb_ram[$];
   txn_t     p0_q[$];
   txn_t     p1_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare_ack(input string tag, input ack_exp_t e, input logic a1,
                              input logic [15:0] r0, input logic [15:0] r1);
      check({tag, "_ack_port"}, {31'd0, a1}, {31'd0, e.port});
      check({tag, "_ack_cycle"}, cyc, e.cyc);
      if (e.rd) check({tag, "_rdata"}, e.port ? {16'd0, r1} : {16'd0, r0}, {16'd0, e.rdata});
   endtask

   // Monitor A: acks and RAM strobes.
   always @(negedge clk) begin
      ack_exp_t e;
      ram_exp_t r;
      if (!rst) begin
         if (ack0 || ack1) begin
            check("a_single_ack", {31'd0, ack0 & ack1}, 32'd0);
            if (sb_a.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_unexpected_ack: got ack0=%0b ack1=%0b, required none (cycle %0d)", ack0, ack1, cyc);
            end else begin
               e = sb_a.pop_front();
               compare_ack("a", e, ack1, rdata0, rdata1);
            end
         end
         if (ram_en) begin
            if (sb_ram.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_unexpected_strobe: got ram_en=1 addr=0x%0h, required none (cycle %0d)", ram_addr, cyc);
            end else begin
               r = sb_ram.pop_front();
               check("a_ram_we", {31'd0, ram_we}, {31'd0, r.we});
               check("a_ram_addr", {17'd0, ram_addr}, {17'd0, r.addr});
               check("a_ram_cycle", cyc, r.cyc);
               if (r.we) check("a_ram_wdata", {16'd0, ram_wdata}, {16'd0, r.wdata});
            end
         end
      end
   end

   // Monitor B: acks only.
   always @(negedge clk) begin
      ack_exp_t e;
      if (!rst_b && (ack0_b || ack1_b)) begin
         check("b_single_ack", {31'd0, ack0_b & ack1_b}, 32'd0);
         if (sb_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_ack: got ack0=%0b ack1=%0b, required none (cycle %0d)", ack0_b, ack1_b, cyc);
         end else begin
            e = sb_b.pop_front();
            compare_ack("b", e, ack1_b, rdata0_b, rdata1_b);
         end
      end
   end

   function automatic void exp_ack(input logic p, input logic rd, input logic [15:0] d, input int c);
      sb_a.push_back('{port: p, rd: rd, rdata: d, cyc: c});
   endfunction

   function automatic void exp_ram(input logic we, input logic [14:0] a, input logic [15:0] d, input int c);
      sb_ram.push_back('{we: we, addr: a, wdata: d, cyc: c});
   endfunction

   // Plays a port's queued transactions on instance A, holding REQ across
   // consecutive transactions and dropping it after the last ack.
   task automatic drive_port(input logic p);
      txn_t t;
      logic got;
      while ((!p && p0_q.size() > 0) || (p && p1_q.size() > 0)) begin
         if (p) t = p1_q.pop_front();
         else   t = p0_q.pop_front();
         if (p) begin we1 = t.we; addr1 = t.addr; wdata1 = t.wdata; req1 = 1'b1; end
         else   begin we0 = t.we; addr0 = t.addr; wdata0 = t.wdata; req0 = 1'b1; end
         got = 1'b0;
         for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = p ? ack1 : ack0;
         end
         if (!got) begin
            checks++; errors++;
            $display("FAIL a_ack_timeout: port %0d got no ack, required one within 40 cycles", p);
         end
      end
      if (p) req1 = 1'b0;
      else   req0 = 1'b0;
   endtask

   task automatic read_b(input logic p, input logic [14:0] a);
      logic got;
      if (p) begin we1_b = 1'b0; addr1_b = a; req1_b = 1'b1; end
      else   begin we0_b = 1'b0; addr0_b = a; req0_b = 1'b1; end
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         got = p ? ack1_b : ack0_b;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL b_ack_timeout: port %0d got no ack, required one within 40 cycles", p);
      end
      req0_b = 1'b0;
      req1_b = 1'b0;
   endtask

   task automatic sync;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1; rst_b = 1'b1;
      {req0, req1, we0, we1} = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      {req0_b, req1_b, we0_b, we1_b} = '0; addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
      mem_a[15'h4000] = 16'h1234;
      mem_b[15'h4000] = 16'h1234;
      mem_b[15'h4001] = 16'hCAFE;

      // Reset for 3 cycles, then idle with no requests.
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; rst_b = 1'b0;
      repeat (4) sync();
      check("idle_ack0", {31'd0, ack0}, 32'd0);
      check("idle_ack1", {31'd0, ack1}, 32'd0);
      check("idle_rdata0", {16'd0, rdata0}, 32'd0);
      check("idle_rdata1", {16'd0, rdata1}, 32'd0);
      check("idle_ram_en", {31'd0, ram_en}, 32'd0);
      check("idle_ram_we", {31'd0, ram_we}, 32'd0);
      check("idle_ram_addr", {17'd0, ram_addr}, 32'd0);
      check("idle_ram_wdata", {16'd0, ram_wdata}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_b_busy", {31'd0, busy_b}, 32'd0);
      check("idle_b_ram_en", {31'd0, ram_en_b}, 32'd0);

      // Single write from port 0.
      sync(); n = cyc;
      exp_ram(1'b1, 15'h0010, 16'hBEEF, n + 1);
      exp_ack(1'b0, 1'b0, 16'h0000, n + 2);
      p0_q.push_back('{we: 1'b1, addr: 15'h0010, wdata: 16'hBEEF});
      drive_port(1'b0);
      check("write_mem", {16'd0, mem_a[15'h0010]}, 32'h0000BEEF);

      // Single read from port 1, latency 1.
      repeat (2) sync(); n = cyc;
      exp_ram(1'b0, 15'h4000, 16'h0000, n + 1);
      exp_ack(1'b1, 1'b1, 16'h1234, n + 3);
      p1_q.push_back('{we: 1'b0, addr: 15'h4000, wdata: 16'h0000});
      drive_port(1'b1);

      // Simultaneous requests right after a fresh reset: order 0,1,0,1.
      sync(); rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      sync(); n = cyc;
      p0_q.push_back('{we: 1'b1, addr: 15'h0020, wdata: 16'h1111});
      p0_q.push_back('{we: 1'b0, addr: 15'h0021, wdata: 16'h0000});
      p1_q.push_back('{we: 1'b1, addr: 15'h0021, wdata: 16'h2222});
      p1_q.push_back('{we: 1'b0, addr: 15'h0020, wdata: 16'h0000});
      exp_ram(1'b1, 15'h0020, 16'h1111, n + 1);  exp_ack(1'b0, 1'b0, 16'h0000, n + 2);
      exp_ram(1'b1, 15'h0021, 16'h2222, n + 4);  exp_ack(1'b1, 1'b0, 16'h0000, n + 5);
      exp_ram(1'b0, 15'h0021, 16'h0000, n + 7);  exp_ack(1'b0, 1'b1, 16'h2222, n + 9);
      exp_ram(1'b0, 15'h0020, 16'h0000, n + 11); exp_ack(1'b1, 1'b1, 16'h1111, n + 13);
      fork
         drive_port(1'b0);
         drive_port(1'b1);
      join
      sync();
      check("rdata0_hold", {16'd0, rdata0}, 32'h00002222);

      // Back-to-back on port 0 while port 1 waits: port 1 goes first.
      repeat (2) sync(); n = cyc;
      p0_q.push_back('{we: 1'b1, addr: 15'h0030, wdata: 16'hAAAA});
      p0_q.push_back('{we: 1'b1, addr: 15'h0031, wdata: 16'hBBBB});
      p1_q.push_back('{we: 1'b0, addr: 15'h0030, wdata: 16'h0000});
      exp_ram(1'b1, 15'h0030, 16'hAAAA, n + 1); exp_ack(1'b0, 1'b0, 16'h0000, n + 2);
      exp_ram(1'b0, 15'h0030, 16'h0000, n + 4); exp_ack(1'b1, 1'b1, 16'hAAAA, n + 6);
      exp_ram(1'b1, 15'h0031, 16'hBBBB, n + 8); exp_ack(1'b0, 1'b0, 16'h0000, n + 9);
      fork
         drive_port(1'b0);
         begin sync(); drive_port(1'b1); end
      join

      // Back-to-back on port 0 alone: second starts in the next IDLE cycle.
      repeat (2) sync(); n = cyc;
      p0_q.push_back('{we: 1'b1, addr: 15'h0040, wdata: 16'h5555});
      p0_q.push_back('{we: 1'b1, addr: 15'h0041, wdata: 16'h6666});
      exp_ram(1'b1, 15'h0040, 16'h5555, n + 1); exp_ack(1'b0, 1'b0, 16'h0000, n + 2);
      exp_ram(1'b1, 15'h0041, 16'h6666, n + 4); exp_ack(1'b0, 1'b0, 16'h0000, n + 5);
      drive_port(1'b0);

      // Latency-3 read on port 1 of instance B.
      sync(); n = cyc;
      sb_b.push_back('{port: 1'b1, rd: 1'b1, rdata: 16'h1234, cyc: n + 5});
      read_b(1'b1, 15'h4000);

      // Reset during WAIT: no ack, back to IDLE, read data cleared.
      repeat (2) sync(); n = cyc;
      we0_b = 1'b0; addr0_b = 15'h4001; req0_b = 1'b1;
      repeat (2) sync();
      check("b_busy_in_wait", {31'd0, busy_b}, 32'd1);
      rst_b = 1'b1; req0_b = 1'b0;
      #1;
      check("b_busy_after_rst", {31'd0, busy_b}, 32'd0);
      check("b_rdata0_after_rst", {16'd0, rdata0_b}, 32'd0);
      check("b_rdata1_after_rst", {16'd0, rdata1_b}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_b = 1'b0;
      repeat (6) sync();
      check("b_rdata0_no_capture", {16'd0, rdata0_b}, 32'd0);

      // Next request after the abandoned read is served normally.
      n = cyc;
      sb_b.push_back('{port: 1'b0, rd: 1'b1, rdata: 16'hCAFE, cyc: n + 5});
      read_b(1'b0, 15'h4001);

      repeat (4) sync();
      check("a_ack_queue_empty", sb_a.size(), 32'd0);
      check("a_ram_queue_empty", sb_ram.size(), 32'd0);
      check("b_ack_queue_empty", sb_b.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
